writeback_unit: RTL

//  Writeback stage for the multi-cycle RISC-V datapath; drives the register file write port.
//  On a start pulse it writes an ALU result, or waits for load data from data memory.

---
 rtl/writeback_unit_if.sv | 30 +++
 rtl/writeback_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// Writeback stage bus: start request, load/ALU operands, memory read return and register file write port.
// The master drives requests and memory data; the slave is the writeback unit.
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            is_load;
  logic [4:0]      rd_in;
  logic [2:0]      funct3;
  logic [1:0]      addr_lo;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;
  logic            busy;
  logic            done;
  logic [1:0]      err_code;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output start, is_load, rd_in, funct3, addr_lo, alu_result, mem_rdata, mem_rvalid,
    input  busy, done, err_code, rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  start, is_load, rd_in, funct3, addr_lo, alu_result, mem_rdata, mem_rvalid,
    output busy, done, err_code, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: writes ALU results or extracted load data to the register file,
// reporting misaligned, illegal-funct3 and memory-timeout loads instead of writing.
module writeback_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok_v;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok_v = 1'b1;
      default:                                ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis_v;
    case (f3)
      3'b001, 3'b101: mis_v = lo[0];
      3'b010:         mis_v = (lo != 2'b00);
      default:        mis_v = 1'b0;
    endcase
    return mis_v;
  endfunction

  // Byte/half lanes are selected from the aligned word, then sign- or zero-extended.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [XLEN-1:0] word,
    input logic [2:0]      f3,
    input logic [1:0]      lo
  );
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] res_v;
    byte_v = word[{lo, 3'b000} +: 8];
    half_v = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res_v = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  res_v = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  res_v = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  res_v = {{(XLEN-16){1'b0}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  state_e          state_r, state_s;
  logic [4:0]      rd_r, rd_s;
  logic [2:0]      funct3_r, funct3_s;
  logic [1:0]      addr_lo_r, addr_lo_s;
  logic [XLEN-1:0] wdata_r, wdata_s;
  logic [1:0]      err_r, err_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            we_r, we_s;

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_s   = state_r;
    rd_s      = rd_r;
    funct3_s  = funct3_r;
    addr_lo_s = addr_lo_r;
    wdata_s   = wdata_r;
    err_s     = ERR_OK;
    cnt_s     = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          rd_s      = bus.rd_in;
          funct3_s  = bus.funct3;
          addr_lo_s = bus.addr_lo;
          if (!bus.is_load) begin
            wdata_s = bus.alu_result;
            err_s   = ERR_OK;
            state_s = ST_WRITE;
          end else if (!f3_legal(bus.funct3)) begin
            err_s   = ERR_ILLEGAL;
            state_s = ST_WRITE;
          end else if (misaligned(bus.funct3, bus.addr_lo)) begin
            err_s   = ERR_MISALIGN;
            state_s = ST_WRITE;
          end else begin
            cnt_s   = '0;
            state_s = ST_WAIT_MEM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        // A response on the last counted cycle still beats the timeout.
        if (bus.mem_rvalid) begin
          wdata_s = extract_load(bus.mem_rdata, funct3_r, addr_lo_r);
          err_s   = ERR_OK;
          state_s = ST_WRITE;
        end else if (cnt_r == CNT_LAST) begin
          err_s   = ERR_TIMEOUT;
          state_s = ST_WRITE;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = ST_WAIT_MEM;
        end
      end
      ST_WRITE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_WRITE);
    we_s   = done_s && (err_s == ERR_OK) && (rd_s != 5'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rd_r      <= 5'd0;
      funct3_r  <= 3'd0;
      addr_lo_r <= 2'd0;
      wdata_r   <= '0;
      err_r     <= ERR_OK;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_r      <= rd_s;
      funct3_r  <= funct3_s;
      addr_lo_r <= addr_lo_s;
      wdata_r   <= wdata_s;
      err_r     <= err_s;
      cnt_r     <= cnt_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      we_r      <= we_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err_code = err_r;
  assign bus.rf_we    = we_r;
  assign bus.rf_rd    = rd_r;
  assign bus.rf_wdata = wdata_r;

endmodule
